io_input_conditioner: RTL and testbench

//  Conditions the raw DE1-SoC slide switches and push-buttons before sc_datamem reads them at 0xffffff00 / 0xffffff10.
//  - Two-flop synchronises every input bit into the dmem_clk domain.
//  - Debounces every bit and provides sticky, clear-able key-press flags, so lw sees glitch-free levels and never misses a press.
//  - Sits between the board pins and the sw/key inputs of sc_datamem.

---
 rtl/io_map_pkg.sv | 15 +
 rtl/debounce_bit.sv | 47 ++++
 rtl/io_input_conditioner.sv | 69 ++++++
 tb/tb_io_input_conditioner.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/io_map_pkg.sv
// Shared IO map for the DE1-SoC memory-mapped peripherals and board pin counts.
// Address decoding itself lives in sc_datamem; only the constants are shared.
package io_map_pkg;

  localparam logic [31:0] IO_ADDR_SW   = 32'hffff_ff00;
  localparam logic [31:0] IO_ADDR_KEY  = 32'hffff_ff10;
  localparam logic [31:0] IO_ADDR_HEX0 = 32'hffff_ff20;
  localparam logic [31:0] IO_ADDR_HEX1 = 32'hffff_ff30;
  localparam logic [31:0] IO_ADDR_LED  = 32'hffff_ff80;

  // key0 is the system reset, so only key[3:1] are conditioned here.
  localparam int NUM_SW  = 10;
  localparam int NUM_KEY = 3;

endpackage

// File: rtl/debounce_bit.sv
// One conditioned input bit: two-flop synchroniser, run-length counter and
// the accepted (stable) level. A new level is accepted only after
// DEBOUNCE_CYCLES consecutive synchronised samples differ from the current one.
module debounce_bit #(
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter int   CNT_W           = 16,
  parameter logic RESET_VAL       = 1'b0
) (
  input  logic dmem_clk,
  input  logic resetn,
  input  logic raw,
  output logic level
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;

  // Synchroniser into dmem_clk; resets to the inactive level of the input.
  always_ff @(posedge dmem_clk or negedge resetn) begin
    if (!resetn) begin
      sync_p0 <= RESET_VAL;
      sync_p1 <= RESET_VAL;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  // Count consecutive differing samples; any agreeing sample restarts the run.
  always_ff @(posedge dmem_clk or negedge resetn) begin
    if (!resetn) begin
      cnt   <= '0;
      level <= RESET_VAL;
    end else if (sync_p1 == level) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      level <= sync_p1;
      cnt   <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/io_input_conditioner.sv
// Conditions raw slide switches and push-buttons for sc_datamem: every bit is
// synchronised and debounced, and each key gets a one-cycle press pulse plus a
// sticky press flag that software clears explicitly.
module io_input_conditioner
  import io_map_pkg::*;
#(
  parameter int NUM_SW          = io_map_pkg::NUM_SW,
  parameter int NUM_KEY         = io_map_pkg::NUM_KEY,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic               dmem_clk,
  input  logic               resetn,
  input  logic [NUM_SW-1:0]  sw_raw,
  input  logic [NUM_KEY-1:0] key_raw,
  input  logic [NUM_KEY-1:0] press_clr,
  output logic [NUM_SW-1:0]  sw,
  output logic [NUM_KEY-1:0] key,
  output logic [NUM_KEY-1:0] key_press,
  output logic [NUM_KEY-1:0] key_event
);

  logic [NUM_KEY-1:0] key_d;
  logic [NUM_KEY-1:0] key_fall;

  for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
    debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W),
      .RESET_VAL       (1'b0)
    ) u_db (
      .dmem_clk (dmem_clk),
      .resetn   (resetn),
      .raw      (sw_raw[i]),
      .level    (sw[i])
    );
  end

  // Keys are active-low, so their idle/reset level is 1.
  for (genvar i = 0; i < NUM_KEY; i++) begin : g_key
    debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W),
      .RESET_VAL       (1'b1)
    ) u_db (
      .dmem_clk (dmem_clk),
      .resetn   (resetn),
      .raw      (key_raw[i]),
      .level    (key[i])
    );
  end

  // A press is a debounced 1->0 of key; releases are ignored.
  assign key_fall = key_d & ~key;

  // Edge detect and sticky flags; a new press overrides a same-cycle clear.
  always_ff @(posedge dmem_clk or negedge resetn) begin
    if (!resetn) begin
      key_d     <= '1;
      key_event <= '0;
      key_press <= '0;
    end else begin
      key_d     <= key;
      key_event <= key_fall;
      key_press <= (key_press & ~press_clr) | key_fall;
    end
  end

endmodule

// File: tb/tb_io_input_conditioner.sv
// Bench for io_input_conditioner with a short debounce window.
module tb_io_input_conditioner;

  localparam int DB  = 4;
  localparam int NSW = 10;
  localparam int NK  = 3;
  localparam int NB  = NSW + NK;
  localparam logic [NB-1:0] RV = {{NK{1'b1}}, {NSW{1'b0}}};

  logic           dmem_clk = 1'b0;
  logic           resetn   = 1'b0;
  logic [NSW-1:0] sw_raw   = '0;
  logic [NK-1:0]  key_raw  = '1;
  logic [NK-1:0]  press_clr = '0;
  logic [NSW-1:0] sw;
  logic [NK-1:0]  key;
  logic [NK-1:0]  key_press;
  logic [NK-1:0]  key_event;

  int errors = 0;
  int checks = 0;

  io_input_conditioner #(
    .NUM_SW          (NSW),
    .NUM_KEY         (NK),
    .DEBOUNCE_CYCLES (DB),
    .CNT_W           (16)
  ) dut (
    .dmem_clk  (dmem_clk),
    .resetn    (resetn),
    .sw_raw    (sw_raw),
    .key_raw   (key_raw),
    .press_clr (press_clr),
    .sw        (sw),
    .key       (key),
    .key_press (key_press),
    .key_event (key_event)
  );

  always #5 dmem_clk = ~dmem_clk;

  // Reference model: raw is seen two edges late; a bit's accepted level flips
  // once the last DB seen samples all disagree with it. Press flags follow the
  // accepted key levels one edge later.
  logic [NB-1:0] m_s1, m_s2, m_stable, m_acc;
  logic [NB-1:0] m_win [DB];
  logic [NK-1:0] m_kd, m_ev, m_pr, m_fell;

  always @(posedge dmem_clk or negedge resetn) begin
    if (!resetn) begin
      m_s1 = RV;
      m_s2 = RV;
      m_stable = RV;
      for (int h = 0; h < DB; h++) m_win[h] = RV;
      m_kd = '1;
      m_ev = '0;
      m_pr = '0;
    end else begin
      for (int h = DB - 1; h > 0; h--) m_win[h] = m_win[h-1];
      m_win[0] = m_s2;
      m_fell = m_kd & ~m_stable[NB-1:NSW];
      m_ev = m_fell;
      m_pr = (m_pr & ~press_clr) | m_fell;
      m_kd = m_stable[NB-1:NSW];
      m_acc = '1;
      for (int h = 0; h < DB; h++) m_acc = m_acc & (m_win[h] ^ m_stable);
      m_stable = m_stable ^ m_acc;
      m_s2 = m_s1;
      m_s1 = {key_raw, sw_raw};
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge dmem_clk);
    #1;
  endtask

  typedef struct {
    logic [NSW-1:0] sw_in;
    logic [NK-1:0]  key_in;
    logic [NK-1:0]  clr_in;
    int             hold;
    logic [NSW-1:0] e_sw;
    logic [NK-1:0]  e_key;
    logic [NK-1:0]  e_ev;
    logic [NK-1:0]  e_pr;
  } vec_t;

  vec_t vt [14];
  int   p;
  logic changed;

  initial begin
    // Directed vectors, applied from a quiet state with DB=4 (latency 6).
    vt[0]  = '{10'h001, 3'b111, 3'b000, 5, 10'h000, 3'b111, 3'b000, 3'b000};
    vt[1]  = '{10'h001, 3'b111, 3'b000, 1, 10'h001, 3'b111, 3'b000, 3'b000};
    vt[2]  = '{10'h001, 3'b101, 3'b000, 5, 10'h001, 3'b111, 3'b000, 3'b000};
    vt[3]  = '{10'h001, 3'b101, 3'b000, 1, 10'h001, 3'b101, 3'b000, 3'b000};
    vt[4]  = '{10'h001, 3'b101, 3'b000, 1, 10'h001, 3'b101, 3'b010, 3'b010};
    vt[5]  = '{10'h001, 3'b101, 3'b000, 1, 10'h001, 3'b101, 3'b000, 3'b010};
    vt[6]  = '{10'h001, 3'b111, 3'b000, 6, 10'h001, 3'b111, 3'b000, 3'b010};
    vt[7]  = '{10'h001, 3'b111, 3'b010, 1, 10'h001, 3'b111, 3'b000, 3'b000};
    vt[8]  = '{10'h001, 3'b110, 3'b000, 3, 10'h001, 3'b111, 3'b000, 3'b000};
    vt[9]  = '{10'h001, 3'b111, 3'b000, 8, 10'h001, 3'b111, 3'b000, 3'b000};
    vt[10] = '{10'h001, 3'b101, 3'b000, 6, 10'h001, 3'b101, 3'b000, 3'b000};
    vt[11] = '{10'h001, 3'b101, 3'b010, 1, 10'h001, 3'b101, 3'b010, 3'b010};
    vt[12] = '{10'h001, 3'b111, 3'b000, 6, 10'h001, 3'b111, 3'b000, 3'b010};
    vt[13] = '{10'h001, 3'b111, 3'b111, 1, 10'h001, 3'b111, 3'b000, 3'b000};

    // Reset with every input active.
    sw_raw = 10'h3FF;
    key_raw = 3'b000;
    tick(3);
    check("rst_sw", 16'(sw), 16'h000);
    check("rst_key", 16'(key), 16'h7);
    check("rst_press", 16'(key_press), 16'h0);
    resetn = 1'b1;
    tick(1);
    check("post_rst_sw", 16'(sw), 16'h000);
    check("post_rst_key", 16'(key), 16'h7);
    tick(4);
    check("edge5_sw", 16'(sw), 16'h000);
    tick(1);
    check("edge6_sw", 16'(sw), 16'h3FF);
    check("edge6_key", 16'(key), 16'h0);
    check("edge6_ev", 16'(key_event), 16'h0);
    tick(1);
    check("edge7_ev", 16'(key_event), 16'h7);
    check("edge7_press", 16'(key_press), 16'h7);
    tick(1);
    check("edge8_ev", 16'(key_event), 16'h0);

    // Return to idle and clear the flags.
    sw_raw = '0;
    key_raw = '1;
    tick(8);
    press_clr = '1;
    tick(1);
    press_clr = '0;
    check("idle_press", 16'(key_press), 16'h0);
    check("idle_sw", 16'(sw), 16'h000);

    for (int i = 0; i < 14; i++) begin
      sw_raw = vt[i].sw_in;
      key_raw = vt[i].key_in;
      press_clr = vt[i].clr_in;
      tick(vt[i].hold);
      check($sformatf("vec%0d_sw", i), 16'(sw), 16'(vt[i].e_sw));
      check($sformatf("vec%0d_key", i), 16'(key), 16'(vt[i].e_key));
      check($sformatf("vec%0d_ev", i), 16'(key_event), 16'(vt[i].e_ev));
      check($sformatf("vec%0d_press", i), 16'(key_press), 16'(vt[i].e_pr));
    end
    press_clr = '0;

    // Clean edge on sw[0] then a 2-cycle toggle that must never pass.
    sw_raw = '0;
    tick(8);
    sw_raw[0] = 1'b1;
    tick(5);
    check("sw0_edge5", 16'(sw[0]), 16'h0);
    tick(1);
    check("sw0_edge6", 16'(sw[0]), 16'h1);
    changed = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (c % 2 == 0) sw_raw[0] = ~sw_raw[0];
      tick(1);
      if (sw[0] !== 1'b1) changed = 1'b1;
    end
    check("sw0_bounce_hold", 16'(changed), 16'h0);
    sw_raw[0] = 1'b1;
    tick(8);

    // Reset in the middle of a sw[5] debounce.
    sw_raw[5] = 1'b1;
    tick(3);
    resetn = 1'b0;
    tick(2);
    check("midrst_sw5", 16'(sw[5]), 16'h0);
    resetn = 1'b1;
    tick(5);
    check("midrst_edge5", 16'(sw[5]), 16'h0);
    tick(1);
    check("midrst_edge6", 16'(sw[5]), 16'h1);

    // Random staggered activity on all inputs against the model.
    for (int seg = 0; seg < 24; seg++) begin
      p = (seg % 3 == 0) ? 3 : ((seg % 3 == 1) ? 12 : 40);
      for (int c = 0; c < 80; c++) begin
        for (int b = 0; b < NSW; b++)
          if ($urandom_range(p - 1) == 0) sw_raw[b] = ~sw_raw[b];
        for (int b = 0; b < NK; b++)
          if ($urandom_range(p - 1) == 0) key_raw[b] = ~key_raw[b];
        press_clr = ($urandom_range(3) == 0) ? NK'($urandom) : '0;
        tick(1);
        check("rnd_sw", 16'(sw), 16'(m_stable[NSW-1:0]));
        check("rnd_key", 16'(key), 16'(m_stable[NB-1:NSW]));
        check("rnd_ev", 16'(key_event), 16'(m_ev));
        check("rnd_press", 16'(key_press), 16'(m_pr));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
